boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 218 +++++++++++++++++++++
 tb/tb_boot_loader.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: receives a boot image over a UART byte stream and writes it
// into the 16x32 boot RAM, then hands the RAM port over to the core.
//
// Frame: magic byte 0xB0, word count N (1..16), then 4*N payload bytes
// (little-endian words). When BOOT_LOADER_CSUM_EN is defined, a final
// byte carrying the XOR of all payload bytes must follow, otherwise the
// load fails.
//
// After a successful load the block is a combinational pass-through from
// the core port to the RAM port and raises fetch_en/done. A failed load
// parks in an error state with err set. Both end states hold until reset.

module boot_loader (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,

    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_addr_o,
    output logic [31:0] mem_wdata_o,

    output logic        fetch_en_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0] S_MAGIC = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;
`ifdef BOOT_LOADER_CSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd6;
`endif

    localparam logic [7:0] MAGIC_BYTE = 8'hB0;
    localparam logic [7:0] MAX_WORDS  = 8'd16;

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [3:0]  word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;
    logic [4:0]  n_words_q;
    logic        done_q;
    logic        err_q;
`ifdef BOOT_LOADER_CSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        ready;
    logic        accept;
    logic        count_ok;
    logic        last_word;

    // Which states are willing to take a byte from the UART.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            S_MAGIC, S_COUNT, S_DATA: ready = 1'b1;
`ifdef BOOT_LOADER_CSUM_EN
            S_CSUM:                   ready = 1'b1;
`endif
            default:                  ready = 1'b0;
        endcase
    end

    // While reset is held every output must read 0, including ready in S_MAGIC.
    assign rx_ready_o = ready & rst_ni;
    assign accept     = rx_valid_i & ready;
    assign count_ok   = (rx_data_i != 8'd0) && (rx_data_i <= MAX_WORDS);
    // n_words_q is 1..16, so the index (never wrapping) stops at n_words_q-1.
    assign last_word  = ({1'b0, word_idx_q} == (n_words_q - 5'd1));

    // Next-state decision for the frame parser.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MAGIC: begin
                if (accept && (rx_data_i == MAGIC_BYTE)) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    state_d = count_ok ? S_DATA : S_ERR;
                end
            end
            S_DATA: begin
                if (accept && (byte_cnt_q == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_word) begin
`ifdef BOOT_LOADER_CSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef BOOT_LOADER_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // State register plus the registered status flags, which rise together
    // with the state they report.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_MAGIC;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
        end
    end

    // Word assembly: count capture, little-endian byte packing and index advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_idx_q <= 4'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            n_words_q  <= 5'd0;
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (accept && count_ok) begin
                        n_words_q  <= rx_data_i[4:0];
                        word_idx_q <= 4'd0;
                        byte_cnt_q <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data_i;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (!last_word) begin
                        word_idx_q <= word_idx_q + 4'd1;
                        byte_cnt_q <= 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BOOT_LOADER_CSUM_EN
    // Running XOR over every accepted payload byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= 8'd0;
        end else if ((state_q == S_DATA) && accept) begin
            csum_q <= csum_q ^ rx_data_i;
        end
    end
`endif

    // RAM port steering: loader writes in S_WRITE, core pass-through in S_DONE.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 4'd0;
        mem_wdata_o = 32'd0;
        core_gnt_o  = 1'b0;
        case (state_q)
            S_WRITE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = word_idx_q;
                mem_wdata_o = word_q;
            end
            S_DONE: begin
                mem_req_o   = core_req_i;
                mem_we_o    = core_we_i;
                mem_addr_o  = core_addr_i;
                mem_wdata_o = core_wdata_i;
                core_gnt_o  = core_req_i;
            end
            default: begin
            end
        endcase
    end

    assign fetch_en_o = done_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: drives byte frames, records RAM writes seen on the
// memory port and compares them with words derived from the frame contents.

module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [3:0]  core_addr = 4'd0;
    logic [31:0] core_wdata = 32'd0;
    logic        core_gnt;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        fetch_en;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;
    int viol = 0;
    int timeouts = 0;
    bit core_noise = 1'b0;

    logic [3:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  stream[$];
    int          waits_q[$];

    always #5 clk = ~clk;

    boot_loader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_ready_o   (rx_ready),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_gnt_o   (core_gnt),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .fetch_en_o   (fetch_en),
        .done_o       (done),
        .err_o        (err)
    );

    // Record every loader write; before done the core must never be granted
    // and the loader never issues reads.
    always @(negedge clk) begin
        if (rst_n && !done) begin
            if (mem_req && mem_we) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (core_gnt || (mem_req && !mem_we)) viol++;
        end
    end

    task automatic apply_reset();
        rx_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_addr_q.delete();
        wr_data_q.delete();
        waits_q.delete();
        timeouts = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int waits, output bit ok);
        rx_valid = 1'b1;
        rx_data = b;
        ok = 1'b0;
        waits = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (core_noise) begin
                core_req = 1'($urandom);
                core_we = 1'($urandom);
                core_addr = 4'($urandom);
                core_wdata = $urandom;
            end
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                waits++;
            end
        end
    endtask

    // Sends the whole stream with rx_valid held high between bytes.
    task automatic send_all();
        int w;
        bit ok;
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], w, ok);
            waits_q.push_back(w);
            if (!ok) timeouts++;
        end
        rx_valid = 1'b0;
    endtask

    // Builds a frame of n words (optional non-magic junk prefix) and the
    // write sequence the RAM must see for it.
    task automatic build_load(input int n, input int njunk);
        logic [7:0]  b;
        logic [7:0]  x;
        logic [31:0] w;
        stream.delete();
        exp_addr.delete();
        exp_data.delete();
        x = 8'd0;
        for (int i = 0; i < njunk; i++) begin
            do b = 8'($urandom); while (b == 8'hB0);
            stream.push_back(b);
        end
        stream.push_back(8'hB0);
        stream.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_addr.push_back(4'(i));
            exp_data.push_back(w);
            for (int k = 0; k < 4; k++) begin
                b = 8'(w >> (8 * k));
                stream.push_back(b);
                x = x ^ b;
            end
        end
`ifdef BOOT_LOADER_CSUM_EN
        stream.push_back(x);
`endif
    endtask

    task automatic test_reset();
        rx_valid = 1'b1;
        rx_data = 8'hB0;
        core_req = 1'b1;
        core_we = 1'b1;
        core_addr = 4'h2;
        core_wdata = 32'hCAFE_F00D;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({rx_ready, core_gnt, mem_req, mem_we, mem_addr, mem_wdata, fetch_en, done, err} !== 43'd0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b gnt=%b req=%b we=%b addr=%h wd=%h fe=%b dn=%b er=%b want all 0",
                     rx_ready, core_gnt, mem_req, mem_we, mem_addr, mem_wdata, fetch_en, done, err);
        end
        rx_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({rx_ready, core_gnt, mem_req, done, err} !== 5'b10000) begin
            bad++;
            $display("FAIL after_reset got rdy=%b gnt=%b req=%b dn=%b er=%b want rdy=1 others 0",
                     rx_ready, core_gnt, mem_req, done, err);
        end
        core_req = 1'b0;
        core_we = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] x;
        logic [31:0] want[3];
        want[0] = 32'h800002B7;
        want[1] = 32'h00028313;
        want[2] = 32'h00028067;
        apply_reset();
        stream = '{8'hB0, 8'h03, 8'hB7, 8'h02, 8'h00, 8'h80, 8'h13, 8'h83,
                   8'h02, 8'h00, 8'h67, 8'h80, 8'h02, 8'h00};
        x = 8'd0;
        for (int i = 2; i < stream.size(); i++) x = x ^ stream[i];
`ifdef BOOT_LOADER_CSUM_EN
        stream.push_back(x);
`endif
        core_noise = 1'b1;
        send_all();
        core_noise = 1'b0;
        core_req = 1'b0;
        core_we = 1'b0;
`ifndef BOOT_LOADER_CSUM_EN
        @(negedge clk);
        total++;
        if ({mem_req, mem_we, mem_addr, done} !== {1'b1, 1'b1, 4'd2, 1'b0}) begin
            bad++;
            $display("FAIL directed_last_write got req=%b we=%b addr=%h done=%b want 1 1 2 0",
                     mem_req, mem_we, mem_addr, done);
        end
        @(posedge clk);
        #1;
`endif
        total++;
        if ({fetch_en, done, err} !== 3'b110) begin
            bad++;
            $display("FAIL directed_status got fe=%b dn=%b er=%b want 1 1 0", fetch_en, done, err);
        end
        total++;
        if (timeouts !== 0 || wr_addr_q.size() !== 3) begin
            bad++;
            $display("FAIL directed_count got writes=%0d timeouts=%0d want 3 0", wr_addr_q.size(), timeouts);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wr_addr_q[i] !== 4'(i) || wr_data_q[i] !== want[i]) begin
                    bad++;
                    $display("FAIL directed_word%0d got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], want[i], i);
                end
            end
        end
    endtask

    task automatic test_magic_discard();
        apply_reset();
        stream = '{8'h55, 8'hAA, 8'hB0, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef BOOT_LOADER_CSUM_EN
        stream.push_back(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`endif
        send_all();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (waits_q[0] !== 0 || waits_q[1] !== 0 || timeouts !== 0) begin
            bad++;
            $display("FAIL magic_junk_accepted got waits=%0d,%0d timeouts=%0d want 0,0,0", waits_q[0], waits_q[1], timeouts);
        end
        total++;
        if (wr_addr_q.size() !== 1) begin
            bad++;
            $display("FAIL magic_write_count got %0d want 1", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 4'd0 || wr_data_q[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL magic_word got %h@%h want deadbeef@0", wr_data_q[0], wr_addr_q[0]);
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL magic_done got %b want 1", done);
        end
    endtask

    task automatic test_bad_count();
        logic [7:0] cnts[2];
        int w;
        bit ok;
        cnts[0] = 8'h11;
        cnts[1] = 8'h00;
        for (int c = 0; c < 2; c++) begin
            apply_reset();
            stream = '{8'hB0, cnts[c]};
            send_all();
            total++;
            if ({err, rx_ready, fetch_en, done} !== 4'b1000) begin
                bad++;
                $display("FAIL bad_count_%h got er=%b rdy=%b fe=%b dn=%b want 1 0 0 0", cnts[c], err, rx_ready, fetch_en, done);
            end
            send_byte(8'hB0, w, ok);
            rx_valid = 1'b0;
            total++;
            if (ok !== 1'b0 || wr_addr_q.size() !== 0 || err !== 1'b1) begin
                bad++;
                $display("FAIL bad_count_terminal_%h got accepted=%b writes=%0d er=%b want 0 0 1", cnts[c], ok, wr_addr_q.size(), err);
            end
        end
    endtask

    task automatic test_full16();
        int stall_err;
        apply_reset();
        build_load(16, 0);
        send_all();
        stall_err = 0;
        for (int j = 0; j < 64; j++) begin
            if (waits_q[j + 2] !== (((j > 0) && (j % 4 == 0)) ? 1 : 0)) stall_err++;
        end
        if (waits_q[0] !== 0 || waits_q[1] !== 0) stall_err++;
        total++;
        if (stall_err !== 0 || timeouts !== 0) begin
            bad++;
            $display("FAIL full16_ready_gaps got %0d wrong gaps, %0d timeouts want 0 0", stall_err, timeouts);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (wr_addr_q.size() !== 16) begin
            bad++;
            $display("FAIL full16_write_count got %0d want 16", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL full16_word%0d got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_data[i], exp_addr[i]);
                end
            end
        end
        total++;
        if ({done, fetch_en, rx_ready} !== 3'b110) begin
            bad++;
            $display("FAIL full16_done got dn=%b fe=%b rdy=%b want 1 1 0", done, fetch_en, rx_ready);
        end
    endtask

    task automatic test_reset_midload();
        apply_reset();
        build_load(2, 0);
        stream = stream[0:5];
        send_all();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        build_load(1, 0);
        send_all();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (wr_addr_q.size() !== 1) begin
            bad++;
            $display("FAIL midreset_write_count got %0d want 1", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 4'd0 || wr_data_q[0] !== exp_data[0]) begin
            bad++;
            $display("FAIL midreset_word got %h@%h want %h@0", wr_data_q[0], wr_addr_q[0], exp_data[0]);
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL midreset_done got %b want 1", done);
        end
    endtask

    task automatic test_core_passthrough();
        apply_reset();
        core_req = 1'b1;
        core_we = 1'b1;
        core_addr = 4'd7;
        @(negedge clk);
        total++;
        if (core_gnt !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL core_blocked got gnt=%b req=%b want 0 0", core_gnt, mem_req);
        end
        build_load(2, 1);
        core_noise = 1'b1;
        send_all();
        core_noise = 1'b0;
        core_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (wr_addr_q.size() !== 2 || wr_data_q[0] !== exp_data[0] || wr_data_q[1] !== exp_data[1] || done !== 1'b1) begin
            bad++;
            $display("FAIL core_load got writes=%0d done=%b want 2 1", wr_addr_q.size(), done);
        end
        core_req = 1'b1;
        core_we = 1'b0;
        core_addr = 4'd2;
        #1;
        total++;
        if ({mem_req, mem_we, mem_addr, core_gnt} !== {1'b1, 1'b0, 4'd2, 1'b1}) begin
            bad++;
            $display("FAIL core_read2 got req=%b we=%b addr=%h gnt=%b want 1 0 2 1", mem_req, mem_we, mem_addr, core_gnt);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            core_req = 1'($urandom);
            core_we = 1'($urandom);
            core_addr = 4'($urandom);
            core_wdata = $urandom;
            #1;
            total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, core_gnt} !== {core_req, core_we, core_addr, core_wdata, core_req}) begin
                bad++;
                $display("FAIL core_pass%0d got req=%b we=%b addr=%h wd=%h gnt=%b want %b %b %h %h %b", i,
                         mem_req, mem_we, mem_addr, mem_wdata, core_gnt, core_req, core_we, core_addr, core_wdata, core_req);
            end
        end
        core_req = 1'b0;
        core_we = 1'b0;
    endtask

    task automatic test_random_loads();
        int n;
        int errs;
        for (int it = 0; it < 5; it++) begin
            apply_reset();
            n = $urandom_range(1, 16);
            build_load(n, $urandom_range(0, 3));
            core_noise = 1'b1;
            send_all();
            core_noise = 1'b0;
            core_req = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            errs = 0;
            if (wr_addr_q.size() !== n) errs++;
            else for (int i = 0; i < n; i++)
                if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) errs++;
            total++;
            if (errs !== 0 || timeouts !== 0 || {done, fetch_en, err} !== 3'b110) begin
                bad++;
                $display("FAIL random_load%0d n=%0d got writes=%0d bad_words=%0d dn=%b fe=%b er=%b want %0d 0 1 1 0",
                         it, n, wr_addr_q.size(), errs, done, fetch_en, err, n);
            end
        end
    endtask

`ifdef BOOT_LOADER_CSUM_EN
    task automatic test_csum_bad();
        int n;
        apply_reset();
        n = $urandom_range(1, 4);
        build_load(n, 0);
        stream[stream.size() - 1] = stream[stream.size() - 1] ^ 8'h01;
        send_all();
        @(posedge clk);
        #1;
        total++;
        if ({err, done, fetch_en, rx_ready} !== 4'b1000 || wr_addr_q.size() !== n) begin
            bad++;
            $display("FAIL csum_bad got er=%b dn=%b fe=%b rdy=%b writes=%0d want 1 0 0 0 %0d",
                     err, done, fetch_en, rx_ready, wr_addr_q.size(), n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_magic_discard();
        test_bad_count();
        test_full16();
        test_reset_midload();
        test_core_passthrough();
        test_random_loads();
`ifdef BOOT_LOADER_CSUM_EN
        test_csum_bad();
`endif
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL loader_port_isolation got %0d bad cycles want 0", viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
